cla_16bits: RTL and testbench
=============================

# cla_16bits

Registered 16-bit adder block computing A+B+Cin with two independent architectures in parallel:
- a two-level carry-lookahead adder (CLA), which is the primary result;
- a ripple-carry adder (RCA), which is the reference result.

Both results and a mismatch flag are registered on one clock. The block sits in the datapath as the main adder and also serves as a self-checking RCA-vs-CLA comparison unit.

## Interface
Parameters:
- WIDTH, 16, operand width. Must be a multiple of 4; 16 is the only verified value.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in
- out_valid  out  1  registered copy of in_valid
- sum_cla  out  WIDTH  CLA sum
- cout_cla  out  1  CLA carry out
- sum_rca  out  WIDTH  RCA sum
- cout_rca  out  1  RCA carry out
- mismatch  out  1  high when {cout_cla,sum_cla} != {cout_rca,sum_rca} for a valid result

## Operation
- Arithmetic: {cout,sum} = a + b + cin, computed in WIDTH+1 bits, unsigned. Overflow appears only on cout; there is no saturation.
- CLA path:
  - per-bit p_i = a_i ^ b_i and g_i = a_i & b_i;
  - 4-bit groups form group propagate PG and group generate GG;
  - a second-level lookahead unit computes group carries c4, c8, c12 and cout from cin, PG and GG;
  - within each group, carries come from lookahead equations, not ripple;
  - sum_i = p_i ^ c_i.
- RCA path: chain of WIDTH full adders (s = a^b^c, co = ab | c(a^b)). The carry ripples bit 0 to bit WIDTH-1.
- On a clock edge with in_valid=1, both results are registered and mismatch is computed combinationally from the two unregistered results, then registered.
- On a clock edge with in_valid=0:
  - out_valid <= 0;
  - sum_cla, cout_cla, sum_rca and cout_rca hold their previous values;
  - mismatch <= 0.
- mismatch must never assert in a correct implementation. It exists for silicon and fault-injection checks.

## Timing
- Latency 1 cycle: operands sampled at edge N appear on the outputs after edge N, with out_valid=1.
- Throughput 1 result per cycle. There is no backpressure and no ready signal.
- Reset (rst=1 at an edge) sets every output to 0: out_valid, sum_cla, cout_cla, sum_rca, cout_rca and mismatch.
- Reset has priority over in_valid. Operands presented in the same cycle as reset are discarded.
- Reset mid-stream: the first valid output after rst deasserts corresponds to the first in_valid sampled with rst=0.
- The combinational path a/b/cin to the registers must close timing at the target clock. The CLA depth is O(log) in group levels; the RCA path is the critical path.

## Structure
- Shared package cla_pkg:
  - GROUP_W = 4;
  - typedef for the WIDTH+1-bit result;
  - function for the 4-bit lookahead carry equations.
- Sub-module rca_parametrizable (parameter N, ports A, B, Cin, Sum, Cout): purely combinational ripple adder, instantiated once with N=WIDTH.
- The CLA core is combinational logic inside cla_16bits (a generate loop over groups plus the second-level lookahead). An optional sub-module cla_group4 holds the 4-bit group logic.
- The output registers and the mismatch compare live in the top module.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=FFFF, b=FFFF -> all outputs 0 and out_valid=0. After release, out_valid stays 0 until in_valid is sampled.
- Directed zero case: a=0000, b=0000, cin=0 -> one cycle later sum_cla=sum_rca=0000, cout=0, mismatch=0, out_valid=1.
- Full carry propagation: a=FFFF, b=0001, cin=0 -> sum=0000, cout=1 on both paths, mismatch=0.
- Alternating pattern with carry in: a=AAAA, b=5555, cin=1 -> sum=0000, cout=1 on both paths. This exercises the longest propagate chain through all groups.
- Back-to-back random: 1000 consecutive cycles with random a, b, cin and in_valid=1 -> each output equals a+b+cin (17 bits) of the previous cycle's operands, mismatch=0 throughout. Insert in_valid=0 gaps and check that the outputs hold and out_valid drops.
- Reset mid-stream: assert rst for 1 cycle during random traffic -> outputs 0 the cycle after, and correct results resume one cycle after the next valid input.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, result type and lookahead carry equations for the
// 16-bit CLA/RCA adder block.
package cla_pkg;

  localparam int unsigned GROUP_W   = 4;
  localparam int unsigned DEF_WIDTH = 16;

  // Carry-out concatenated above the sum: {cout, sum}
  typedef logic [DEF_WIDTH:0] sum_ext_t;

  // Carries into positions 0..3 of a 4-wide slice, given bit (or group)
  // propagate/generate and the slice carry-in. Flat two-level equations.
  function automatic logic [3:0] carries4(input logic [3:0] p,
                                          input logic [3:0] g,
                                          input logic       c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Generate term of a 4-wide slice (carry out when carry-in is 0)
  function automatic logic gen4(input logic [3:0] p,
                                input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit CLA group: in-group lookahead carries and sum bits from the
// group carry-in supplied by the second-level lookahead unit.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p   = i_a ^ i_b;
  assign w_g   = i_a & i_b;
  assign w_c   = carries4(w_p, w_g, i_c);
  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/rca_parametrizable.sv
// Purely combinational N-bit ripple-carry adder, used as the reference path.
module rca_parametrizable #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[N];

endmodule

// File: rtl/cla_16bits.sv
// Registered adder: two-level CLA (primary) and RCA (reference) computed in
// parallel, with a registered RCA-vs-CLA mismatch flag.
module cla_16bits
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_cla,
  output logic             cout_cla,
  output logic [WIDTH-1:0] sum_rca,
  output logic             cout_rca,
  output logic             mismatch
);

  localparam int unsigned NG  = WIDTH / GROUP_W;
  localparam int unsigned NB  = (NG + GROUP_W - 1) / GROUP_W;
  localparam int unsigned NGP = NB * GROUP_W;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NGP-1:0]   w_pg;
  logic [NGP-1:0]   w_gg;
  logic [NGP-1:0]   w_gc;
  logic [NB:0]      w_bc;
  logic [WIDTH-1:0] w_sum_cla;
  logic             w_cout_cla;
  logic [WIDTH-1:0] w_sum_rca;
  logic             w_cout_rca;
  logic             w_mismatch;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum_cla;
  logic             r_cout_cla;
  logic [WIDTH-1:0] r_sum_rca;
  logic             r_cout_rca;
  logic             r_mismatch;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Group PG/GG come straight from the operands so the group carries never
  // depend on the group sum logic. Padding groups are transparent (PG=1,
  // GG=0) so a block carry passes through them unchanged.
  always_comb begin
    w_pg = '1;
    w_gg = '0;
    for (int unsigned gi = 0; gi < NG; gi++) begin
      w_pg[gi] = &w_p[gi*GROUP_W +: GROUP_W];
      w_gg[gi] = gen4(w_p[gi*GROUP_W +: GROUP_W], w_g[gi*GROUP_W +: GROUP_W]);
    end
  end

  // Second-level lookahead over groups of four groups (c4, c8, c12, cout
  // for WIDTH=16); wider operands chain these blocks.
  always_comb begin
    w_gc    = '0;
    w_bc    = '0;
    w_bc[0] = cin;
    for (int unsigned k = 0; k < NB; k++) begin
      w_gc[k*GROUP_W +: GROUP_W] = carries4(w_pg[k*GROUP_W +: GROUP_W],
                                            w_gg[k*GROUP_W +: GROUP_W], w_bc[k]);
      w_bc[k+1] = gen4(w_pg[k*GROUP_W +: GROUP_W], w_gg[k*GROUP_W +: GROUP_W])
                | (&w_pg[k*GROUP_W +: GROUP_W] & w_bc[k]);
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .i_a   (a[gi*GROUP_W +: GROUP_W]),
      .i_b   (b[gi*GROUP_W +: GROUP_W]),
      .i_c   (w_gc[gi]),
      .o_sum (w_sum_cla[gi*GROUP_W +: GROUP_W])
    );
  end

  assign w_cout_cla = w_bc[NB];

  rca_parametrizable #(
    .N (WIDTH)
  ) u_rca (
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .Sum  (w_sum_rca),
    .Cout (w_cout_rca)
  );

  assign w_mismatch = ({w_cout_cla, w_sum_cla} != {w_cout_rca, w_sum_rca});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_sum_cla  <= '0;
      r_cout_cla <= 1'b0;
      r_sum_rca  <= '0;
      r_cout_rca <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_valid    <= in_valid;
      r_mismatch <= in_valid & w_mismatch;
      if (in_valid) begin
        r_sum_cla  <= w_sum_cla;
        r_cout_cla <= w_cout_cla;
        r_sum_rca  <= w_sum_rca;
        r_cout_rca <= w_cout_rca;
      end
    end
  end

  assign out_valid = r_valid;
  assign sum_cla   = r_sum_cla;
  assign cout_cla  = r_cout_cla;
  assign sum_rca   = r_sum_rca;
  assign cout_rca  = r_cout_rca;
  assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_cla_16bits.sv
// Scoreboard bench for cla_16bits: driver pushes expected {cout,sum} per
// accepted operand set, monitor pops and compares on each valid output.
module tb_cla_16bits;
  import cla_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum_cla;
  logic        cout_cla;
  logic [15:0] sum_rca;
  logic        cout_rca;
  logic        mismatch;

  sum_ext_t exp_q[$];
  int       errors = 0;
  int       checks = 0;

  always #5 clk = ~clk;

  cla_16bits #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum_cla   (sum_cla),
    .cout_cla  (cout_cla),
    .sum_rca   (sum_rca),
    .cout_rca  (cout_rca),
    .mismatch  (mismatch)
  );

  task automatic check(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 17-bit unsigned arithmetic
  function automatic sum_ext_t model(input logic [15:0] x, input logic [15:0] y,
                                     input logic c);
    return sum_ext_t'(x) + sum_ext_t'(y) + sum_ext_t'(c);
  endfunction

  task automatic step(input logic r, input logic v, input logic [15:0] ta,
                      input logic [15:0] tb, input logic tc, input sum_ext_t e);
    rst      = r;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    if (v && !r) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: decides what the outputs must look like from what was sampled
  // at the edge, comparing against the scoreboard queue or the held value.
  initial begin
    sum_ext_t hold;
    sum_ext_t e;
    logic     s_rst;
    logic     s_v;
    hold = '0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_v   = in_valid;
      @(negedge clk);
      if (s_rst) begin
        check("rst_out_valid", 17'(out_valid), 17'h0);
        check("rst_cla", {cout_cla, sum_cla}, 17'h0);
        check("rst_rca", {cout_rca, sum_rca}, 17'h0);
        check("rst_mismatch", 17'(mismatch), 17'h0);
        hold = '0;
      end else if (s_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got valid output %h expected none",
                   {cout_cla, sum_cla});
        end else begin
          e = exp_q.pop_front();
          check("out_valid", 17'(out_valid), 17'h1);
          check("cla_result", {cout_cla, sum_cla}, e);
          check("rca_result", {cout_rca, sum_rca}, e);
          check("mismatch", 17'(mismatch), 17'h0);
          hold = e;
        end
      end else begin
        check("gap_out_valid", 17'(out_valid), 17'h0);
        check("gap_hold_cla", {cout_cla, sum_cla}, hold);
        check("gap_hold_rca", {cout_rca, sum_rca}, hold);
        check("gap_mismatch", 17'(mismatch), 17'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rv;
    logic        rr;

    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, '0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, '0);
    step(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b1, '0);

    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 17'h00000);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    step(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 17'h10000);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    step(1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 17'h08000);
    step(1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, '0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 7) != 0);
      rr = (i == 500);
      step(rr, rv, ra, rb, rc, model(ra, rb, rc));
    end

    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, '0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, '0);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
